// File: rtl/scratch_mem_pkg.sv
// -----------------------------------------------------------------------------
// scratch_mem_pkg
//   Shared constants for the scratch memory subsystem: default geometry of the
//   scratch SRAM, default read latency and lock bound, the requester ids used
//   by the per-stage memory controllers, and a small one-hot helper.
// -----------------------------------------------------------------------------
package scratch_mem_pkg;

    // Default geometry of the scratch SRAM and its arbiter.
    localparam int unsigned SCRATCH_NREQ     = 4;
    localparam int unsigned SCRATCH_AW       = 16;
    localparam int unsigned SCRATCH_DW       = 64;
    localparam int unsigned SCRATCH_RD_LAT   = 2;
    localparam int unsigned SCRATCH_LOCK_MAX = 8;

    // Requester ids (bit position in req/gnt/rd_vld).
    localparam int unsigned REQ_HIST  = 0;
    localparam int unsigned REQ_CDF   = 1;
    localparam int unsigned REQ_DIVRD = 2;
    localparam int unsigned REQ_DIVWT = 3;

    // One-hot decode of a requester id; wide enough for the largest arbiter.
    function automatic logic [7:0] id_to_onehot(input logic [2:0] id);
        return 8'(1) << id;
    endfunction

endpackage

// File: rtl/scratch_mem_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Round-robin pick over NREQ request lines. The search starts at the
//   pointer and wraps around; the pointer itself is owned here and moves to
//   one past whichever requester actually received the grant (which may be a
//   lock owner rather than this module's own pick).
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low reset
//   req       in   NREQ request lines
//   upd       in   a grant was issued this cycle
//   upd_id    in   id of the granted requester
//   pick_vld  out  at least one request is pending
//   pick_id   out  first requester found searching upward from the pointer
// -----------------------------------------------------------------------------
module rr_arbiter
    import scratch_mem_pkg::*;
#(
    parameter int unsigned NREQ = SCRATCH_NREQ
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic                     upd,
    input  logic [$clog2(NREQ)-1:0]  upd_id,
    output logic                     pick_vld,
    output logic [$clog2(NREQ)-1:0]  pick_id
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0] ptr_q, ptr_d;

    // First set request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr_q) + k) % NREQ;
            if (!pick_vld && req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = (32'(upd_id) == NREQ - 1) ? '0 : upd_id + IDW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/scratch_mem_arbiter.sv
// -----------------------------------------------------------------------------
// scratch_mem_arbiter
//   Shares the single-port scratch SRAM between NREQ requesters (histogram,
//   CDF, divider read, divider write). One access is granted per cycle by
//   round-robin; a requester may hold the grant with req_lock for
//   read-modify-write bursts, bounded by LOCK_MAX grants per run. The winning
//   command is registered towards the SRAM and read data is routed back to
//   the issuing requester through a tag pipe matching the SRAM read latency.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req        in   per-requester access request, held until granted
//   req_wt     in   per-requester 1 = write, 0 = read
//   req_lock   in   per-requester keep-grant request
//   req_addr   in   packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in   packed write data, requester i at [i*DW +: DW]
//   gnt        out  one-hot combinational grant (command accepted)
//   rd_vld     out  one-hot read-return strobe
//   rd_data    out  read data, broadcast to all requesters
//   mem_addr   out  registered SRAM address
//   mem_rd_en  out  registered SRAM read strobe
//   mem_wt_en  out  registered SRAM write strobe
//   mem_wdata  out  registered SRAM write data
//   mem_rdata  in   SRAM read data, valid RD_LAT cycles after mem_rd_en
//   lock_err   out  sticky, a lock run was cut short by LOCK_MAX
// -----------------------------------------------------------------------------
module scratch_mem_arbiter
    import scratch_mem_pkg::*;
#(
    parameter int unsigned NREQ     = SCRATCH_NREQ,
    parameter int unsigned AW       = SCRATCH_AW,
    parameter int unsigned DW       = SCRATCH_DW,
    parameter int unsigned RD_LAT   = SCRATCH_RD_LAT,
    parameter int unsigned LOCK_MAX = SCRATCH_LOCK_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_wt,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rd_vld,
    output logic [DW-1:0]        rd_data,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_rd_en,
    output logic                 mem_wt_en,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata,
    output logic                 lock_err
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(LOCK_MAX + 1);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic            owner_vld_q, owner_vld_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            lock_err_q, lock_err_d;

    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            mem_rd_en_q;
    logic            mem_wt_en_q;
    logic [IDW-1:0]  cmd_id_q;

    logic [RD_LAT-1:0] tag_vld_q;
    logic [IDW-1:0]    tag_id_q [RD_LAT];

    // ---------------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------------
    logic            pick_vld;
    logic [IDW-1:0]  pick_id;
    logic            lock_req;
    logic            lock_hold;
    logic            lock_ovr;
    logic            gnt_vld;
    logic [IDW-1:0]  gnt_id;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .upd      (gnt_vld),
        .upd_id   (gnt_id),
        .pick_vld (pick_vld),
        .pick_id  (pick_id)
    );

    // lock_cnt counts re-grants after the grant that took ownership, so a
    // run has lock_cnt+1 grants; the run is capped at LOCK_MAX grants, after
    // which one arbitration falls back to plain round-robin.
    always_comb begin
        lock_req  = owner_vld_q && req[owner_q] && req_lock[owner_q];
        lock_hold = lock_req && ((32'(lock_cnt_q) + 32'd1) < LOCK_MAX);
        lock_ovr  = lock_req && !lock_hold;
        // gnt is forced low while reset is asserted.
        gnt_vld   = reset && (lock_hold || pick_vld);
        gnt_id    = lock_hold ? owner_q : pick_id;
        gnt       = gnt_vld ? NREQ'(id_to_onehot(3'(gnt_id))) : '0;
    end

    // Ownership follows the granted requester's lock bit; without a grant
    // (owner dropped req, or nobody requesting) ownership is released.
    always_comb begin
        owner_vld_d = 1'b0;
        owner_d     = owner_q;
        lock_cnt_d  = '0;
        lock_err_d  = lock_err_q || lock_ovr;
        if (gnt_vld) begin
            owner_vld_d = req_lock[gnt_id];
            owner_d     = gnt_id;
            if (!lock_ovr && owner_vld_q && (gnt_id == owner_q)) begin
                lock_cnt_d = lock_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_vld_q <= 1'b0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            lock_err_q  <= 1'b0;
        end else begin
            owner_vld_q <= owner_vld_d;
            owner_q     <= owner_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_err_q  <= lock_err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Command register towards the SRAM
    // ---------------------------------------------------------------------
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_wt;

    always_comb begin
        sel_addr  = req_addr[32'(gnt_id) * AW +: AW];
        sel_wdata = req_wdata[32'(gnt_id) * DW +: DW];
        sel_wt    = req_wt[gnt_id];
    end

    // Address and data hold when idle; only the strobes drop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wt_en_q <= 1'b0;
            cmd_id_q    <= '0;
        end else if (gnt_vld) begin
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_rd_en_q <= !sel_wt;
            mem_wt_en_q <= sel_wt;
            cmd_id_q    <= gnt_id;
        end else begin
            mem_rd_en_q <= 1'b0;
            mem_wt_en_q <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Read-return tag pipe: RD_LAT stages so the tag leaves in the same
    // cycle the SRAM presents the data for that read.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q <= '0;
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_vld_q[0] <= mem_rd_en_q;
            tag_id_q[0]  <= cmd_id_q;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        rd_vld  = '0;
        rd_data = '0;
        if (tag_vld_q[RD_LAT-1]) begin
            rd_vld  = NREQ'(id_to_onehot(3'(tag_id_q[RD_LAT-1])));
            rd_data = mem_rdata;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wt_en = mem_wt_en_q;
    assign lock_err  = lock_err_q;

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
module tb_scratch_mem_arbiter;
    import scratch_mem_pkg::*;

    localparam int NREQ     = 4;
    localparam int AW       = 16;
    localparam int DW       = 64;
    localparam int RD_LAT   = 2;
    localparam int LOCK_MAX = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req, req_wt, req_lock;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_wdata;
    logic [NREQ-1:0]     gnt, rd_vld;
    logic [DW-1:0]       rd_data, mem_wdata, mem_rdata;
    logic [AW-1:0]       mem_addr;
    logic                mem_rd_en, mem_wt_en, lock_err;

    always #5 clk = ~clk;

    scratch_mem_arbiter #(
        .NREQ     (NREQ),
        .AW       (AW),
        .DW       (DW),
        .RD_LAT   (RD_LAT),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_wt    (req_wt),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rd_vld    (rd_vld),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_wt_en (mem_wt_en),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lock_err  (lock_err)
    );

    // Memory model: read data derived from the address, RD_LAT cycles after mem_rd_en.
    function automatic logic [DW-1:0] rdata_f(input logic [AW-1:0] a);
        return {16'hBEEF, a, 16'h5A5A, ~a};
    endfunction

    logic [DW-1:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        rpipe[0] <= mem_rd_en ? rdata_f(mem_addr) : '0;
        for (int k = 1; k < RD_LAT; k++) rpipe[k] <= rpipe[k-1];
    end
    assign mem_rdata = rpipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard queues.
    typedef struct { int id; int cyc; } gnt_t;
    typedef struct { int cyc; logic wt; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_t;
    typedef struct { int id; int cyc; logic [DW-1:0] data; } rd_t;

    gnt_t q_gnt[$];
    cmd_t q_cmd[$];
    rd_t  q_rd[$];

    logic [AW-1:0] addr_tbl [NREQ];
    logic [DW-1:0] wdat_tbl [NREQ];

    // Monitor: compares every output event against the head of its queue.
    gnt_t eg;
    cmd_t ec;
    rd_t  er;
    always @(negedge clk) begin
        if (gnt != '0) begin
            if (q_gnt.size() == 0) check("gnt unexpected", 128'(gnt), 128'(0));
            else begin
                eg = q_gnt.pop_front();
                check("gnt cyc|onehot", {32'(cyc), 32'(gnt)}, {32'(eg.cyc), 32'(1 << eg.id)});
            end
        end
        if (mem_rd_en || mem_wt_en) begin
            if (q_cmd.size() == 0)
                check("cmd unexpected", {mem_rd_en, mem_wt_en}, 128'(0));
            else begin
                ec = q_cmd.pop_front();
                check("cmd cyc|rd|wt|addr|wdata",
                      {32'(cyc), mem_rd_en, mem_wt_en, mem_addr, mem_wdata},
                      {32'(ec.cyc), ~ec.wt, ec.wt, ec.addr, ec.wdata});
            end
        end
        if (rd_vld != '0) begin
            if (q_rd.size() == 0) check("rd_vld unexpected", 128'(rd_vld), 128'(0));
            else begin
                er = q_rd.pop_front();
                check("rd cyc|rd_vld|rd_data", {32'(cyc), 32'(rd_vld), rd_data},
                      {32'(er.cyc), 32'(1 << er.id), er.data});
            end
        end
    end

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        addr_tbl[i] = a;
        wdat_tbl[i] = d;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One cycle of stimulus; id is the hand-computed winner (-1 for none).
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] w,
                        input logic [NREQ-1:0] l, input int id, input bit track);
        req = r;
        req_wt = w;
        req_lock = l;
        if (id >= 0) begin
            q_gnt.push_back('{id, cyc});
            if (track) begin
                q_cmd.push_back('{cyc + 1, w[id], addr_tbl[id], wdat_tbl[id]});
                if (!w[id]) q_rd.push_back('{id, cyc + 1 + RD_LAT, rdata_f(addr_tbl[id])});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, '0, '0, -1, 1'b1);
    endtask

    task automatic check_zero(input string name);
        check({name, " ctrl"}, {gnt, rd_vld, mem_rd_en, mem_wt_en, lock_err, mem_addr}, 128'(0));
        check({name, " data"}, {mem_wdata, rd_data}, 128'(0));
    endtask

    task automatic check_empty(input string name);
        check(name, 128'(q_gnt.size() + q_cmd.size() + q_rd.size()), 128'(0));
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        @(negedge clk);
        check_zero("reset state");
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req = '0;
        req_wt = '0;
        req_lock = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) set_src(i, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        reset_dut();

        // 1: single read from requester 0, addr 64.
        set_src(0, 16'd64, 64'h0);
        step(4'b0001, 4'b0000, 4'b0000, 0, 1'b1);
        idle(RD_LAT + 2);
        check_empty("t1 drain");

        // 2: all four requesting reads, plain rotation from pointer 0.
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_src(i, 16'(100 + i), 64'(64'h2000 + i));
        for (int k = 0; k < 8; k++) step(4'b1111, 4'b0000, 4'b0000, k % 4, 1'b1);
        idle(RD_LAT + 2);
        check_empty("t2 drain");

        // 3: requester 0 writes under lock against requester 2 reads.
        check("t3 lock_err before", 128'(lock_err), 128'(0));
        set_src(0, 16'd300, 64'h3333_0000);
        set_src(2, 16'd302, 64'h0);
        for (int k = 0; k < LOCK_MAX; k++) step(4'b0101, 4'b0001, 4'b0001, 0, 1'b1);
        step(4'b0101, 4'b0001, 4'b0001, 2, 1'b1);
        check("t3 lock_err set", 128'(lock_err), 128'(1));
        step(4'b0101, 4'b0001, 4'b0001, 0, 1'b1);
        idle(RD_LAT + 2);
        check_empty("t3 drain");
        check("t3 lock_err sticky", 128'(lock_err), 128'(1));

        // 4: requester 1 write moves pointer to 2, then read 2 beats write 3.
        set_src(1, 16'd50, 64'h11);
        step(4'b0010, 4'b0010, 4'b0000, 1, 1'b1);
        set_src(3, 16'd129, 64'hA5);
        set_src(2, 16'd65, 64'h0);
        step(4'b1100, 4'b1000, 4'b0000, 2, 1'b1);
        step(4'b1000, 4'b1000, 4'b0000, 3, 1'b1);
        idle(RD_LAT + 2);
        check_empty("t4 drain");

        // 5: reset one cycle after a read grant discards the read.
        set_src(0, 16'd7, 64'h0);
        step(4'b0001, 4'b0000, 4'b0000, 0, 1'b0);
        reset = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        check_zero("t5 in reset");
        @(posedge clk);
        #1;
        check_zero("t5 in reset late");
        req = '0;
        reset = 1'b1;
        idle(RD_LAT + 3);
        check_empty("t5 no rd_vld");

        // 6: back-to-back reads from 0 then 1.
        set_src(0, 16'd200, 64'h0);
        set_src(1, 16'd201, 64'h0);
        step(4'b0001, 4'b0000, 4'b0000, 0, 1'b1);
        step(4'b0010, 4'b0000, 4'b0000, 1, 1'b1);
        idle(RD_LAT + 2);
        check_empty("t6 drain");
        check("t6 idle addr hold|strobes", {mem_addr, mem_rd_en, mem_wt_en},
              {16'd201, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
